// File: rtl/digital_analog_interface.sv
// Bus-side write port for an external D/A converter: TBR latch, soc/eoc 4-phase handshake, status register.
// Optional handshake watchdog is compiled in when DAI_TIMEOUT_EN is defined.
module digital_analog_interface #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       s_,
    input  logic       ior_,
    input  logic       iow_,
    input  logic       a0,
    inout  wire  [7:0] d7_d0,
    output logic [7:0] x7_x0,
    output logic       soc,
    input  logic       eoc
);

    localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_N-1:0] s_sync, ior_sync, iow_sync, a0_sync, eoc_sync;
    logic              wr_cond_q, rd_cond_q;
    logic              wr_cond_c, rd_cond_c, wr_ev_c, rd_end_c, eoc_s_c;
    logic              rd_sel_c;
    logic [7:0]        status_c;
    logic              rdy_q, rdy_d, ovr_q, ovr_d, soc_d, err_flag;
    logic [7:0]        x_d;

    // Bus strobes and eoc are asynchronous; strobes reset to their inactive level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s_sync    <= '1;
            ior_sync  <= '1;
            iow_sync  <= '1;
            a0_sync   <= '0;
            eoc_sync  <= '1;
            wr_cond_q <= 1'b0;
            rd_cond_q <= 1'b0;
        end else begin
            s_sync    <= {s_sync[SYNC_N-2:0], s_};
            ior_sync  <= {ior_sync[SYNC_N-2:0], ior_};
            iow_sync  <= {iow_sync[SYNC_N-2:0], iow_};
            a0_sync   <= {a0_sync[SYNC_N-2:0], a0};
            eoc_sync  <= {eoc_sync[SYNC_N-2:0], eoc};
            wr_cond_q <= wr_cond_c;
            rd_cond_q <= rd_cond_c;
        end
    end

    assign wr_cond_c = ~s_sync[SYNC_N-1] & ~iow_sync[SYNC_N-1] & ~a0_sync[SYNC_N-1];
    assign rd_cond_c = ~s_sync[SYNC_N-1] & ~ior_sync[SYNC_N-1] &  a0_sync[SYNC_N-1];
    assign wr_ev_c   = wr_cond_c & ~wr_cond_q;
    assign rd_end_c  = rd_cond_q & ~rd_cond_c;
    assign eoc_s_c   = eoc_sync[SYNC_N-1];

    // Status read is decoded from the raw strobes so the CPU sees data within its access
    assign status_c = {5'b0, err_flag, ovr_q, rdy_q};
    assign rd_sel_c = ~s_ & ~ior_ & a0;
    assign d7_d0    = rd_sel_c ? status_c : 8'hzz;

`ifdef DAI_TIMEOUT_EN
    localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign err_flag = err_q;
`else
    assign err_flag = 1'b0;
`endif

    // Next-state, handshake outputs and status flag updates
    always_comb begin
        state_d = state_q;
        soc_d   = soc;
        x_d     = x7_x0;
        rdy_d   = rdy_q;
        ovr_d   = ovr_q;
`ifdef DAI_TIMEOUT_EN
        err_d   = err_q;
        cnt_d   = cnt_q;
`endif

        // Clear first so a same-cycle set wins
        if (rd_end_c) begin
            ovr_d = 1'b0;
        end
        if (wr_ev_c && (state_q != IDLE)) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (wr_ev_c) begin
                    x_d     = d7_d0;
                    soc_d   = 1'b1;
                    rdy_d   = 1'b0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!eoc_s_c) begin
                    soc_d   = 1'b0;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (eoc_s_c) begin
                    rdy_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef DAI_TIMEOUT_EN
        if (rd_end_c) begin
            err_d = 1'b0;
        end
        // Counter restarts on every state change and only runs while a handshake is open
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != IDLE) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                soc_d   = 1'b0;
                rdy_d   = 1'b1;
                err_d   = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            soc     <= 1'b0;
            x7_x0   <= 8'h00;
            rdy_q   <= 1'b1;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            soc     <= soc_d;
            x7_x0   <= x_d;
            rdy_q   <= rdy_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef DAI_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_digital_analog_interface.sv
// Directed bench for digital_analog_interface: bus writes/reads, DAC handshake model, status flags.
// Timeout checks are compiled only when DAI_TIMEOUT_EN is defined.
module tb_digital_analog_interface;

    localparam int unsigned PERIOD = 10;
    localparam int unsigned SYNC   = 2;
    localparam int unsigned TO_CYC = 16;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       s_      = 1'b1;
    logic       ior_    = 1'b1;
    logic       iow_    = 1'b1;
    logic       a0      = 1'b0;
    logic       eoc     = 1'b1;
    logic       tb_drv  = 1'b0;
    logic [7:0] tb_data = 8'h00;
    logic       dac_en  = 1'b1;
    wire  [7:0] d7_d0;
    logic [7:0] x7_x0;
    logic       soc;

    int  n_cmp     = 0;
    int  n_bad     = 0;
    int  soc_rises = 0;
    time t_iow_fall = 0;
    time t_soc_rise = 0;
    time t_soc_fall = 0;
    time t_eoc_fall = 0;

    assign d7_d0 = tb_drv ? tb_data : 8'hzz;

    always #(PERIOD / 2) clock = ~clock;

    digital_analog_interface #(
        .TIMEOUT_CYCLES(TO_CYC),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .s_    (s_),
        .ior_  (ior_),
        .iow_  (iow_),
        .a0    (a0),
        .d7_d0 (d7_d0),
        .x7_x0 (x7_x0),
        .soc   (soc),
        .eoc   (eoc)
    );

    always @(posedge soc) begin
        t_soc_rise = $time;
        soc_rises++;
    end

    always @(negedge soc) t_soc_fall = $time;

    // DAC model: drop eoc 2 clocks after soc, raise it 5 clocks later
    always begin
        @(posedge soc);
        if (dac_en) begin
            repeat (2) @(posedge clock);
            #1 eoc = 1'b0;
            t_eoc_fall = $time;
            repeat (5) @(posedge clock);
            #1 eoc = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic sel_n, input logic addr, input logic [7:0] data);
        s_         = sel_n;
        a0         = addr;
        tb_data    = data;
        tb_drv     = 1'b1;
        iow_       = 1'b0;
        t_iow_fall = $time;
        repeat (4) @(negedge clock);
        iow_   = 1'b1;
        s_     = 1'b1;
        a0     = 1'b0;
        tb_drv = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic bus_read(output logic [7:0] val);
        s_   = 1'b0;
        a0   = 1'b1;
        ior_ = 1'b0;
        @(negedge clock);
        val = d7_d0;
        repeat (2) @(negedge clock);
        ior_ = 1'b1;
        s_   = 1'b1;
        a0   = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    // Bench drives a pattern; any DUT drive would corrupt it
    task automatic probe_float(input string tag, input logic sv, input logic rv, input logic av);
        tb_data = 8'h50;
        tb_drv  = 1'b1;
        s_      = sv;
        ior_    = rv;
        a0      = av;
        @(negedge clock);
        check(tag, 32'(d7_d0), 32'h50);
        s_     = 1'b1;
        ior_   = 1'b1;
        a0     = 1'b0;
        tb_drv = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #(PERIOD * 5000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rd;
        int         base;
        logic [7:0] xs;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_soc", 32'(soc), 32'h0);
        check("rst_x", 32'(x7_x0), 32'h00);
        bus_read(rd);
        check("rst_status", 32'(rd), 32'h01);
        probe_float("rst_float", 1'b1, 1'b1, 1'b0);

        // Single write with normal handshake
        base = soc_rises;
        bus_write(1'b0, 1'b0, 8'hA5);
        check("wr_soc_delay", 32'(t_soc_rise - t_iow_fall), 32'((SYNC + 1) * PERIOD - PERIOD / 2));
        check("wr_x", 32'(x7_x0), 32'hA5);
        bus_read(rd);
        check("busy_status", 32'(rd), 32'h00);
        repeat (10) @(negedge clock);
        check("ack_soc_delay", 32'(t_soc_fall - t_eoc_fall), 32'((SYNC + 1) * PERIOD - 1));
        check("wr_pulses", 32'(soc_rises - base), 32'd1);
        bus_read(rd);
        check("done_status", 32'(rd), 32'h01);

        // Overrun: second write lands while busy
        base = soc_rises;
        bus_write(1'b0, 1'b0, 8'h3C);
        bus_write(1'b0, 1'b0, 8'hC3);
        repeat (10) @(negedge clock);
        check("ovr_x", 32'(x7_x0), 32'h3C);
        check("ovr_pulses", 32'(soc_rises - base), 32'd1);
        bus_read(rd);
        check("ovr_status", 32'(rd), 32'h03);
        bus_read(rd);
        check("ovr_cleared", 32'(rd), 32'h01);

        // Back-to-back: second write event falls on the first cycle back in IDLE
        base = soc_rises;
        bus_write(1'b0, 1'b0, 8'h11);
        repeat (5) @(negedge clock);
        bus_write(1'b0, 1'b0, 8'h22);
        check("b2b_soc_delay", 32'(t_soc_rise - t_iow_fall), 32'((SYNC + 1) * PERIOD - PERIOD / 2));
        check("b2b_x", 32'(x7_x0), 32'h22);
        repeat (12) @(negedge clock);
        check("b2b_pulses", 32'(soc_rises - base), 32'd2);
        bus_read(rd);
        check("b2b_status", 32'(rd), 32'h01);

        // Decode: STATUS-address write and deselected write are ignored
        base = soc_rises;
        xs   = x7_x0;
        bus_write(1'b0, 1'b1, 8'h5A);
        bus_write(1'b1, 1'b0, 8'hFF);
        repeat (5) @(negedge clock);
        check("dec_x", 32'(x7_x0), 32'(xs));
        check("dec_pulses", 32'(soc_rises - base), 32'd0);
        probe_float("rd_tbr_float", 1'b0, 1'b0, 1'b0);
        probe_float("desel_float", 1'b1, 1'b0, 1'b1);

`ifdef DAI_TIMEOUT_EN
        // DAC never acknowledges: watchdog aborts the handshake
        dac_en = 1'b0;
        bus_write(1'b0, 1'b0, 8'h99);
        repeat (16) @(negedge clock);
        check("to_soc", 32'(soc), 32'h0);
        check("to_len", 32'(t_soc_fall - t_soc_rise), 32'(TO_CYC * PERIOD));
        bus_read(rd);
        check("to_status", 32'(rd), 32'h05);
        bus_read(rd);
        check("to_cleared", 32'(rd), 32'h01);
        check("to_x", 32'(x7_x0), 32'h99);
`endif

        // Reset in the middle of WAIT_ACK
        dac_en = 1'b0;
        bus_write(1'b0, 1'b0, 8'h77);
        check("hs_soc", 32'(soc), 32'h1);
        check("hs_x", 32'(x7_x0), 32'h77);
        reset = 1'b1;
        #1;
        check("rst_async_soc", 32'(soc), 32'h0);
        check("rst_async_x", 32'(x7_x0), 32'h00);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        bus_read(rd);
        check("post_rst_status", 32'(rd), 32'h01);
        probe_float("post_rst_float", 1'b1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
